// File: rtl/billiard_pkg.sv
// Shared billiard constants, FSM state type and velocity helpers used by the
// motion stage, collision resolver and draw logic.
package billiard_pkg;

   localparam int DEF_FRAC_BITS       = 6;
   localparam int DEF_FRICTION_PERIOD = 4;
   localparam int POS_W               = 11 + DEF_FRAC_BITS;

   localparam int VEL_MAX = 1023;
   localparam int VEL_MIN = -1024;

   // Legal top-left ball coordinates in pixels.
   localparam int TABLE_X_MIN = 0;
   localparam int TABLE_X_MAX = 608;
   localparam int TABLE_Y_MIN = 0;
   localparam int TABLE_Y_MAX = 448;
   localparam int INIT_X_PX   = 320;
   localparam int INIT_Y_PX   = 240;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE,
      ST_BOUNCE,
      ST_FRICT,
      ST_DONE
   } motion_state_t;

   // |v|, with the one unrepresentable magnitude (-1024) saturated to 1023.
   function automatic logic signed [10:0] sat_abs(input logic signed [10:0] v);
      logic signed [10:0] r;
      if (v == 11'(VEL_MIN))
         r = 11'(VEL_MAX);
      else if (v[10])
         r = -v;
      else
         r = v;
      return r;
   endfunction

endpackage

// File: rtl/axis_integrator.sv
// One axis of ball motion: sub-pixel position accumulator and velocity with
// load, integrate, cushion-bounce and friction-step operations.
module axis_integrator
   import billiard_pkg::*;
#(
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int MIN       = TABLE_X_MIN,
   parameter int MAX       = TABLE_X_MAX,
   parameter int INIT      = INIT_X_PX
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               doLoad,
   input  logic               doAdd,
   input  logic               doBounce,
   input  logic               doFrict,
   input  logic signed [10:0] loadVel,
   output logic signed [10:0] posInt,
   output logic signed [10:0] vel,
   output logic               bounced
);

   localparam int PW = 11 + FRAC_BITS;

   localparam logic signed [10:0]   MIN_V    = 11'(MIN);
   localparam logic signed [10:0]   MAX_V    = 11'(MAX);
   localparam logic signed [10:0]   INIT_V   = 11'(INIT);
   localparam logic signed [PW-1:0] MIN_POS  = {MIN_V, {FRAC_BITS{1'b0}}};
   localparam logic signed [PW-1:0] MAX_POS  = {MAX_V, {FRAC_BITS{1'b0}}};
   localparam logic signed [PW-1:0] INIT_POS = {INIT_V, {FRAC_BITS{1'b0}}};

   logic signed [PW-1:0] pos;
   logic signed [PW-1:0] posNext;
   logic signed [PW-1:0] velExt;
   logic signed [10:0]   velNext;
   logic signed [10:0]   velMag;

   assign posInt = pos[PW-1:FRAC_BITS];
   assign velExt = {{FRAC_BITS{vel[10]}}, vel};
   assign velMag = sat_abs(vel);

   always_comb begin
      posNext = pos;
      velNext = vel;
      bounced = 1'b0;
      if (doLoad) begin
         velNext = loadVel;
      end else if (doAdd) begin
         posNext = pos + velExt;
      end else if (doBounce) begin
         // posInt is the floor of the sub-pixel position
         if (posInt < MIN_V) begin
            posNext = MIN_POS;
            velNext = velMag;
            bounced = 1'b1;
         end else if (posInt > MAX_V) begin
            posNext = MAX_POS;
            velNext = -velMag;
            bounced = 1'b1;
         end
      end else if (doFrict) begin
         if (vel[10])
            velNext = vel + 11'sd1;
         else if (vel != '0)
            velNext = vel - 11'sd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos <= INIT_POS;
         vel <= '0;
      end else begin
         pos <= posNext;
         vel <= velNext;
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Per-ball motion stage: once per frame integrates, bounces off cushions and
// applies friction; takes new velocities from the collision resolver or cue.
module ball_motion
   import billiard_pkg::*;
#(
   parameter int FRAC_BITS       = DEF_FRAC_BITS,
   parameter int FRICTION_PERIOD = DEF_FRICTION_PERIOD,
   parameter int X_MIN           = TABLE_X_MIN,
   parameter int X_MAX           = TABLE_X_MAX,
   parameter int Y_MIN           = TABLE_Y_MIN,
   parameter int Y_MAX           = TABLE_Y_MAX,
   parameter int INIT_X          = INIT_X_PX,
   parameter int INIT_Y          = INIT_Y_PX
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               collisionOccurred,
   input  logic signed [10:0] collVelX,
   input  logic signed [10:0] collVelY,
   input  logic               hitValid,
   input  logic signed [10:0] hitVelX,
   input  logic signed [10:0] hitVelY,
   output logic               hitReady,
   output logic signed [10:0] ballTopLeftPosX,
   output logic signed [10:0] ballTopLeftPosY,
   output logic signed [10:0] ballVelX,
   output logic signed [10:0] ballVelY,
   output logic               ballMoving,
   output logic               wallHit,
   output logic               frameDone
);

   localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);

   motion_state_t      state;
   motion_state_t      nextState;
   logic [CNT_W-1:0]   frameCnt;
   logic               pendValid;
   logic signed [10:0] pendVelX;
   logic signed [10:0] pendVelY;
   logic               bounceFlag;
   logic               frictWrap;
   logic               doLoad;
   logic               doAdd;
   logic               doBounce;
   logic               doFrict;
   logic signed [10:0] loadVelX;
   logic signed [10:0] loadVelY;
   logic               bouncedX;
   logic               bouncedY;

   assign ballMoving = (ballVelX != '0) || (ballVelY != '0);
   assign hitReady   = (state == ST_IDLE) && !ballMoving;
   assign frameDone  = (state == ST_DONE);
   assign wallHit    = (state == ST_DONE) && bounceFlag;
   assign frictWrap  = ballMoving && (frameCnt == CNT_LAST);

   always_comb begin
      nextState = state;
      doLoad    = 1'b0;
      doAdd     = 1'b0;
      doBounce  = 1'b0;
      doFrict   = 1'b0;
      loadVelX  = collVelX;
      loadVelY  = collVelY;
      unique case (state)
         ST_IDLE: begin
            if (collisionOccurred) begin
               doLoad = 1'b1;
            end else if (hitValid && hitReady) begin
               doLoad   = 1'b1;
               loadVelX = hitVelX;
               loadVelY = hitVelY;
            end
            if (startOfFrame)
               nextState = ST_MOVE;
         end
         ST_MOVE: begin
            doAdd     = 1'b1;
            nextState = ST_BOUNCE;
         end
         ST_BOUNCE: begin
            doBounce  = 1'b1;
            nextState = ST_FRICT;
         end
         ST_FRICT: begin
            doFrict   = frictWrap;
            nextState = ST_DONE;
         end
         ST_DONE: begin
            // A pulse arriving in DONE is newer than anything pending
            if (collisionOccurred) begin
               doLoad = 1'b1;
            end else if (pendValid) begin
               doLoad   = 1'b1;
               loadVelX = pendVelX;
               loadVelY = pendVelY;
            end
            nextState = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         frameCnt   <= '0;
         pendValid  <= 1'b0;
         pendVelX   <= '0;
         pendVelY   <= '0;
         bounceFlag <= 1'b0;
      end else begin
         state <= nextState;
         if ((state == ST_MOVE || state == ST_BOUNCE || state == ST_FRICT) && collisionOccurred) begin
            pendValid <= 1'b1;
            pendVelX  <= collVelX;
            pendVelY  <= collVelY;
         end else if (state == ST_DONE) begin
            pendValid <= 1'b0;
         end
         if (state == ST_BOUNCE && (bouncedX || bouncedY))
            bounceFlag <= 1'b1;
         else if (state == ST_DONE)
            bounceFlag <= 1'b0;
         if (state == ST_FRICT)
            frameCnt <= (!ballMoving || frictWrap) ? '0 : frameCnt + 1'b1;
      end
   end

   axis_integrator #(
      .FRAC_BITS (FRAC_BITS),
      .MIN       (X_MIN),
      .MAX       (X_MAX),
      .INIT      (INIT_X)
   ) u_axis_x (
      .clk      (clk),
      .reset    (reset),
      .doLoad   (doLoad),
      .doAdd    (doAdd),
      .doBounce (doBounce),
      .doFrict  (doFrict),
      .loadVel  (loadVelX),
      .posInt   (ballTopLeftPosX),
      .vel      (ballVelX),
      .bounced  (bouncedX)
   );

   axis_integrator #(
      .FRAC_BITS (FRAC_BITS),
      .MIN       (Y_MIN),
      .MAX       (Y_MAX),
      .INIT      (INIT_Y)
   ) u_axis_y (
      .clk      (clk),
      .reset    (reset),
      .doLoad   (doLoad),
      .doAdd    (doAdd),
      .doBounce (doBounce),
      .doFrict  (doFrict),
      .loadVel  (loadVelY),
      .posInt   (ballTopLeftPosY),
      .vel      (ballVelY),
      .bounced  (bouncedY)
   );

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: table of cue/frame vectors, directed corner sequences
// and randomized traffic checked against a sub-pixel arithmetic model.
module tb_ball_motion;

   localparam int FB     = 6;
   localparam int FP     = 4;
   localparam int XMIN   = 0;
   localparam int XMAX   = 608;
   localparam int YMIN   = 0;
   localparam int YMAX   = 448;
   localparam int X0     = 320;
   localparam int Y0     = 240;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               startOfFrame = 1'b0;
   logic               collisionOccurred = 1'b0;
   logic signed [10:0] collVelX = '0;
   logic signed [10:0] collVelY = '0;
   logic               hitValid = 1'b0;
   logic signed [10:0] hitVelX = '0;
   logic signed [10:0] hitVelY = '0;
   logic               hitReady;
   logic signed [10:0] ballTopLeftPosX;
   logic signed [10:0] ballTopLeftPosY;
   logic signed [10:0] ballVelX;
   logic signed [10:0] ballVelY;
   logic               ballMoving;
   logic               wallHit;
   logic               frameDone;

   int vectors    = 0;
   int miscompares = 0;

   // reference model state: position in 1/64 px units, velocity, friction count
   int mpx, mpy, mvx, mvy, mcnt;

   typedef struct {
      int hx;
      int hy;
      int nf;
      int ex;
      int ey;
      int evx;
      int evy;
   } vec_t;

   vec_t tbl[6];

   ball_motion #(
      .FRAC_BITS       (FB),
      .FRICTION_PERIOD (FP),
      .X_MIN           (XMIN),
      .X_MAX           (XMAX),
      .Y_MIN           (YMIN),
      .Y_MAX           (YMAX),
      .INIT_X          (X0),
      .INIT_Y          (Y0)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .startOfFrame      (startOfFrame),
      .collisionOccurred (collisionOccurred),
      .collVelX          (collVelX),
      .collVelY          (collVelY),
      .hitValid          (hitValid),
      .hitVelX           (hitVelX),
      .hitVelY           (hitVelY),
      .hitReady          (hitReady),
      .ballTopLeftPosX   (ballTopLeftPosX),
      .ballTopLeftPosY   (ballTopLeftPosY),
      .ballVelX          (ballVelX),
      .ballVelY          (ballVelY),
      .ballMoving        (ballMoving),
      .wallHit           (wallHit),
      .frameDone         (frameDone)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat_mag(input int v);
      int m;
      m = (v < 0) ? -v : v;
      return (m > 1023) ? 1023 : m;
   endfunction

   function automatic int sgn(input int v);
      return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
   endfunction

   function automatic int rand_vel();
      if ($urandom_range(0, 15) == 0)
         return -1024;
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   task automatic model_reset();
      mpx = X0 * 64; mpy = Y0 * 64; mvx = 0; mvy = 0; mcnt = 0;
   endtask

   task automatic model_axis(inout int p, inout int v, input int lo, input int hi, inout bit hit);
      int ip;
      ip = p >>> FB;
      if (ip < lo) begin
         p = lo * 64; v = sat_mag(v); hit = 1'b1;
      end else if (ip > hi) begin
         p = hi * 64; v = -sat_mag(v); hit = 1'b1;
      end
   endtask

   task automatic model_frame(output bit hit);
      hit = 1'b0;
      mpx += mvx;
      mpy += mvy;
      model_axis(mpx, mvx, XMIN, XMAX, hit);
      model_axis(mpy, mvy, YMIN, YMAX, hit);
      if (mvx != 0 || mvy != 0) begin
         mcnt++;
         if (mcnt == FP) begin
            mcnt = 0;
            mvx -= sgn(mvx);
            mvy -= sgn(mvy);
         end
      end else begin
         mcnt = 0;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_posX"}, int'(ballTopLeftPosX), mpx >>> FB);
      check({tag, "_posY"}, int'(ballTopLeftPosY), mpy >>> FB);
      check({tag, "_velX"}, int'(ballVelX), mvx);
      check({tag, "_velY"}, int'(ballVelY), mvy);
      check({tag, "_moving"}, int'(ballMoving), int'(mvx != 0 || mvy != 0));
      check({tag, "_hitReady"}, int'(hitReady), int'(mvx == 0 && mvy == 0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic cue(input int hx, input int hy);
      bit rdy;
      rdy = (mvx == 0 && mvy == 0);
      check("cue_hitReady", int'(hitReady), int'(rdy));
      hitValid = 1'b1; hitVelX = 11'(hx); hitVelY = 11'(hy);
      tick();
      hitValid = 1'b0;
      if (rdy) begin mvx = hx; mvy = hy; end
      check("cue_velX", int'(ballVelX), mvx);
      check("cue_velY", int'(ballVelY), mvy);
   endtask

   task automatic collide(input int cx, input int cy, input bit withHit, input int hx, input int hy);
      collisionOccurred = 1'b1; collVelX = 11'(cx); collVelY = 11'(cy);
      hitValid = withHit; hitVelX = 11'(hx); hitVelY = 11'(hy);
      tick();
      collisionOccurred = 1'b0; hitValid = 1'b0;
      mvx = cx; mvy = cy;
      check("coll_velX", int'(ballVelX), mvx);
      check("coll_velY", int'(ballVelY), mvy);
   endtask

   // One frame; collAt 0/1/2 pulses a collision in the MOVE/BOUNCE/FRICT cycle.
   task automatic frame(input int collAt, input int cx, input int cy, output bit sawWall);
      bit mhit;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("move_hitReady", int'(hitReady), 0);
      if (collAt == 0) begin
         collisionOccurred = 1'b1; collVelX = 11'(cx); collVelY = 11'(cy);
      end
      tick();
      collisionOccurred = 1'b0;
      check("integ_posX", int'(ballTopLeftPosX), (mpx + mvx) >>> FB);
      check("integ_posY", int'(ballTopLeftPosY), (mpy + mvy) >>> FB);
      if (collAt == 1) begin
         collisionOccurred = 1'b1; collVelX = 11'(cx); collVelY = 11'(cy);
      end
      tick();
      collisionOccurred = 1'b0;
      check("frict_frameDone", int'(frameDone), 0);
      if (collAt == 2) begin
         collisionOccurred = 1'b1; collVelX = 11'(cx); collVelY = 11'(cy);
      end
      tick();
      collisionOccurred = 1'b0;
      model_frame(mhit);
      if (collAt >= 0) begin mvx = cx; mvy = cy; end
      sawWall = wallHit;
      check("done_frameDone", int'(frameDone), 1);
      check("done_wallHit", int'(wallHit), int'(mhit));
      tick();
      check("idle_frameDone", int'(frameDone), 0);
      check("idle_wallHit", int'(wallHit), 0);
      check_state("frame");
   endtask

   initial begin
      bit w;
      bit seen;
      int r;
      int ca;

      tbl[0] = '{hx: 128,  hy: -64, nf: 1, ex: 322, ey: 239, evx: 128,  evy: -64};
      tbl[1] = '{hx: 128,  hy: -64, nf: 4, ex: 328, ey: 236, evx: 127,  evy: -63};
      tbl[2] = '{hx: 0,    hy: 0,   nf: 3, ex: 320, ey: 240, evx: 0,    evy: 0};
      tbl[3] = '{hx: 64,   hy: 32,  nf: 5, ex: 324, ey: 242, evx: 63,   evy: 31};
      tbl[4] = '{hx: -100, hy: 1,   nf: 2, ex: 316, ey: 240, evx: -100, evy: 1};
      tbl[5] = '{hx: 1,    hy: -1,  nf: 8, ex: 320, ey: 239, evx: 0,    evy: 0};

      // reset values
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      check("rst_frameDone", int'(frameDone), 0);
      check("rst_wallHit", int'(wallHit), 0);
      check_state("rst");
      check("rst_posX_abs", int'(ballTopLeftPosX), 320);
      check("rst_posY_abs", int'(ballTopLeftPosY), 240);

      // stationary ball over three frames
      for (int i = 0; i < 3; i++)
         frame(-1, 0, 0, w);

      // table-driven cue + frame vectors
      for (int i = 0; i < 6; i++) begin
         do_reset();
         cue(tbl[i].hx, tbl[i].hy);
         for (int f = 0; f < tbl[i].nf; f++)
            frame(-1, 0, 0, w);
         check("tbl_posX", int'(ballTopLeftPosX), tbl[i].ex);
         check("tbl_posY", int'(ballTopLeftPosY), tbl[i].ey);
         check("tbl_velX", int'(ballVelX), tbl[i].evx);
         check("tbl_velY", int'(ballVelY), tbl[i].evy);
      end

      // right cushion: clamp to X_MAX, velocity reversed, wallHit with frameDone
      do_reset();
      cue(1023, 0);
      seen = 1'b0;
      for (int f = 0; f < 40 && !seen; f++)
         frame(-1, 0, 0, seen);
      check("wallR_seen", int'(seen), 1);
      check("wallR_posX", int'(ballTopLeftPosX), XMAX);
      check("wallR_velNeg", int'(ballVelX < 0), 1);

      // top cushion with saturating -1024
      do_reset();
      cue(0, -1024);
      seen = 1'b0;
      for (int f = 0; f < 40 && !seen; f++)
         frame(-1, 0, 0, seen);
      check("wallT_seen", int'(seen), 1);
      check("wallT_posY", int'(ballTopLeftPosY), YMIN);
      check("wallT_velPos", int'(ballVelY > 0), 1);

      // collision during MOVE overrides the frame's result
      do_reset();
      cue(128, -64);
      frame(0, -50, 30, w);
      check("collMove_velX", int'(ballVelX), -50);
      check("collMove_velY", int'(ballVelY), 30);
      check("collMove_posX", int'(ballTopLeftPosX), 322);

      // second pulse before DONE replaces the pending value
      frame(-1, 0, 0, w);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      collisionOccurred = 1'b1; collVelX = 11'(11); collVelY = 11'(12);
      tick();
      collVelX = 11'(-21); collVelY = 11'(22);
      tick();
      collisionOccurred = 1'b0;
      tick();
      tick();
      check("repl_velX", int'(ballVelX), -21);
      check("repl_velY", int'(ballVelY), 22);

      // cue dropped while moving; collision wins over cue
      do_reset();
      cue(5, 0);
      check("busy_hitReady", int'(hitReady), 0);
      cue(100, 100);
      collide(0, 0, 1'b1, 77, 77);
      check("prio_hitReady", int'(hitReady), 1);
      collide(10, -10, 1'b1, 77, 77);

      // reset during BOUNCE discards the frame and the pending load
      do_reset();
      cue(200, 100);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      collisionOccurred = 1'b1; collVelX = 11'(7); collVelY = 11'(7);
      tick();
      collisionOccurred = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check("midrst_frameDone", int'(frameDone), 0);
      check("midrst_wallHit", int'(wallHit), 0);
      check_state("midrst");
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_quiet", int'(frameDone || wallHit), 0);
      end
      frame(-1, 0, 0, w);

      // randomized traffic against the model
      do_reset();
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            cue(rand_vel() / 4, rand_vel() / 4);
         end else if (r == 2) begin
            collide(rand_vel() / 8, rand_vel() / 8, 1'($urandom_range(0, 1)), rand_vel(), rand_vel());
         end else if (r == 3 && $urandom_range(0, 3) == 0) begin
            do_reset();
            check_state("rnd_rst");
         end else begin
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            frame(ca, rand_vel() / 8, rand_vel() / 8, w);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
